disp_decimal_entry: RTL and testbench
=====================================

// Module: disp_decimal_entry
// PURPOSE
//  Keypad-side counterpart of the decimal display path: assembles decimal digit key events into an 8-bit value.
//  Supports sign toggle, backspace, clear and enter. On enter it commits a signed or unsigned value to the RPN stack.
//  Sits between the debounced keypad decoder and the stack controller.
//  entry_value drives the display chain live while the user types.
// PARAMETERS
//  MAX_DIGITS      3         max decimal digits accepted (1..3)
//  TIMEOUT_CYCLES  50000000  idle cycles before auto-clear (used only with DEC_ENTRY_TIMEOUT_EN)
// PORTS
//  clk           in   1  system clock, rising edge
//  rst_n         in   1  asynchronous active-low reset
//  digit_valid   in   1  1-cycle strobe, digit key pressed
//  digit         in   4  BCD digit 0..9, sampled with digit_valid; 10..15 ignored
//  neg_toggle    in   1  1-cycle strobe, flip sign
//  backspace     in   1  1-cycle strobe, drop last digit
//  enter         in   1  1-cycle strobe, commit entry
//  clear         in   1  1-cycle strobe, abandon entry
//  non_signed    in   1  1 = unsigned range 0..255; 0 = signed range -128..127
//  value_out     out  8  committed value (two's complement when signed)
//  value_valid   out  1  1-cycle pulse, value_out is new
//  entry_active  out  1  1 while in ENTRY
//  entry_value   out  8  live signed/unsigned value of the current entry
//  digit_count   out  2  digits currently held
//  entry_err     out  1  1-cycle pulse, key rejected
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; magnitude 0; neg 0.
//  - All strobes are sampled on the clk rising edge; outputs are registered, so response appears the next cycle.
//  - One action per cycle. Priority: clear > enter > backspace > neg_toggle > digit_valid. Lower-priority strobes in the same cycle are dropped silently.
//  - FSM states: IDLE, ENTRY.
//  - IDLE:
//    - digit_valid -> ENTRY with mag = digit, count = 1.
//    - neg_toggle  -> ENTRY with mag = 0, count = 0, neg = !non_signed.
//    - enter, backspace, clear -> no effect.
//  - ENTRY, digit:
//    - Accepted iff count < MAX_DIGITS and mag*10 + d is within range: <= 128 signed, <= 255 unsigned.
//    - Accepted: mag = mag*10 + d, count + 1.
//    - Rejected: state unchanged, entry_err = 1 for one cycle.
//  - ENTRY, neg_toggle:
//    - Signed mode: neg = !neg.
//    - Unsigned mode: ignored, no error.
//  - ENTRY, backspace: mag = mag/10, count - 1. At count 0 -> IDLE with neg cleared.
//  - ENTRY, clear: -> IDLE; mag, neg, count = 0. value_out is unchanged.
//  - ENTRY, enter:
//    - count == 0 -> IDLE, no pulse.
//    - Legal result (signed: -128..127; unsigned: mag <= 255) -> value_out = neg ? -mag : mag (neg forced 0 if non_signed), value_valid = 1 for one cycle, -> IDLE, accumulator cleared.
//    - Illegal (+128 signed, or mag > 127 after switching to signed mid-entry) -> entry_err pulse, stays ENTRY, nothing changes.
//  - non_signed is evaluated live, not latched at entry start. Switching mode mid-entry never modifies mag; neg is honoured only while signed.
//  - entry_value: neg ? -mag : mag, truncated to 8 bits; -128 shown as 8'h80. It is 0 in IDLE.
//  - Back-to-back strobes on consecutive cycles are each processed; there is no busy period.
//  - Reset asserted mid-entry: immediate return to reset values; no value_valid is emitted.
// CONFIGURATION
//  DEC_ENTRY_TIMEOUT_EN defined:
//   - A counter runs in ENTRY and restarts on any accepted or rejected strobe.
//   - On reaching TIMEOUT_CYCLES-1 the block behaves as clear: -> IDLE, no pulse, no err.
//   - The counter is held at 0 in IDLE.
//  Undefined: no counter is synthesised, TIMEOUT_CYCLES is unused, and entry persists indefinitely.
// TESTING
//  1 Signed: digits 1,2,7, enter -> value_out 8'h7F, value_valid for 1 cycle, digit_count 0, entry_active 0.
//  2 Signed: neg, 1,2,8, enter -> value_out 8'h80. Then 1,2,8, enter with no neg -> entry_err, still ENTRY, entry_value 8'h80.
//  3 Unsigned: 2,5,6 -> third digit rejected, entry_err, entry_value 25. Then 5, enter -> value_out 8'hFF.
//  4 Signed: 4,5, backspace, backspace, backspace -> entry_value 45->4->0, IDLE after 2nd backspace, 3rd no effect. Also enter+clear same cycle -> clear wins, no pulse.
//  5 Unsigned: 2,0,0, set non_signed=0, enter -> entry_err; set non_signed=1, enter -> value_out 8'hC8.
//  6 rst_n low mid-entry (mag 12) -> all outputs 0 asynchronously. With DEC_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=8: digit 3 then idle 8 cycles -> IDLE, no pulse.

Source files
------------

// File: rtl/disp_decimal_entry.sv
// rtl/disp_decimal_entry.sv - keypad decimal entry assembler feeding the RPN stack
// Optional idle auto-clear is enabled by defining DEC_ENTRY_TIMEOUT_EN.
module disp_decimal_entry #(
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       neg_toggle,
    input  logic       backspace,
    input  logic       enter,
    input  logic       clear,
    input  logic       non_signed,
    output logic [7:0] value_out,
    output logic       value_valid,
    output logic       entry_active,
    output logic [7:0] entry_value,
    output logic [1:0] digit_count,
    output logic       entry_err
);

    typedef enum logic {IDLE, ENTRY} state_t;

    state_t     state, state_nx;
    logic [7:0] mag, mag_nx;
    logic       neg, neg_nx;
    logic [1:0] count, count_nx;
    logic [7:0] value_out_nx;
    logic       value_valid_nx, entry_err_nx;

    logic [11:0] mag_x10;
    logic [11:0] limit;
    logic        digit_legal, room_left, enter_ok, neg_eff, any_strobe, timeout_fire;
    logic [7:0]  signed_mag;

    assign any_strobe = clear | enter | backspace | neg_toggle | digit_valid;

`ifdef DEC_ENTRY_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] idle_tmr;

    assign timeout_fire = (state == ENTRY) && !any_strobe && (idle_tmr == TW'(TIMEOUT_CYCLES - 1));

    // Any strobe, accepted or not, counts as user activity and restarts the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_tmr <= '0;
        else if (state != ENTRY || any_strobe || timeout_fire)
            idle_tmr <= '0;
        else
            idle_tmr <= idle_tmr + 1'b1;
    end
`else
    wire unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        mag_x10     = ({4'd0, mag} * 12'd10) + {8'd0, digit};
        limit       = non_signed ? 12'd255 : 12'd128;
        digit_legal = (digit <= 4'd9);
        room_left   = (int'(count) < MAX_DIGITS);
        // Sign only matters while signed mode is selected; mag is never rewritten on a mode switch.
        neg_eff     = neg & ~non_signed;
        signed_mag  = neg_eff ? (8'd0 - mag) : mag;
        enter_ok    = non_signed ? 1'b1 : (neg ? (mag <= 8'd128) : (mag <= 8'd127));
    end

    always_comb begin
        state_nx       = state;
        mag_nx         = mag;
        neg_nx         = neg;
        count_nx       = count;
        value_out_nx   = value_out;
        value_valid_nx = 1'b0;
        entry_err_nx   = 1'b0;
        if (state == IDLE) begin
            if (clear || enter || backspace) begin
                state_nx = IDLE;
            end else if (neg_toggle) begin
                state_nx = ENTRY;
                mag_nx   = 8'd0;
                count_nx = 2'd0;
                neg_nx   = ~non_signed;
            end else if (digit_valid && digit_legal) begin
                state_nx = ENTRY;
                mag_nx   = {4'd0, digit};
                count_nx = 2'd1;
                neg_nx   = 1'b0;
            end
        end else begin
            if (clear || timeout_fire) begin
                state_nx = IDLE;
                mag_nx   = 8'd0;
                neg_nx   = 1'b0;
                count_nx = 2'd0;
            end else if (enter) begin
                if (count == 2'd0 || enter_ok) begin
                    if (count != 2'd0) begin
                        value_out_nx   = signed_mag;
                        value_valid_nx = 1'b1;
                    end
                    state_nx = IDLE;
                    mag_nx   = 8'd0;
                    neg_nx   = 1'b0;
                    count_nx = 2'd0;
                end else begin
                    entry_err_nx = 1'b1;
                end
            end else if (backspace) begin
                if (count <= 2'd1) begin
                    state_nx = IDLE;
                    mag_nx   = 8'd0;
                    neg_nx   = 1'b0;
                    count_nx = 2'd0;
                end else begin
                    mag_nx   = mag / 8'd10;
                    count_nx = count - 2'd1;
                end
            end else if (neg_toggle) begin
                if (!non_signed)
                    neg_nx = ~neg;
            end else if (digit_valid && digit_legal) begin
                if (room_left && (mag_x10 <= limit)) begin
                    mag_nx   = mag_x10[7:0];
                    count_nx = count + 2'd1;
                end else begin
                    entry_err_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mag         <= 8'd0;
            neg         <= 1'b0;
            count       <= 2'd0;
            value_out   <= 8'd0;
            value_valid <= 1'b0;
            entry_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            mag         <= mag_nx;
            neg         <= neg_nx;
            count       <= count_nx;
            value_out   <= value_out_nx;
            value_valid <= value_valid_nx;
            entry_err   <= entry_err_nx;
        end
    end

    assign entry_active = (state == ENTRY);
    assign entry_value  = (state == ENTRY) ? signed_mag : 8'd0;
    assign digit_count  = count;

endmodule

// File: tb/tb_disp_decimal_entry.sv
// tb/tb_disp_decimal_entry.sv - directed vector bench for disp_decimal_entry
module tb_disp_decimal_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digit_valid, neg_toggle, backspace, enter, clear, non_signed;
    logic [3:0] digit;
    logic [7:0] value_out, entry_value;
    logic       value_valid, entry_active, entry_err;
    logic [1:0] digit_count;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0] strobes;   // clear, enter, backspace, neg_toggle, digit_valid
        logic [3:0] dig;
        logic       ns;
        logic [7:0] vo;
        logic       vv;
        logic       ea;
        logic [7:0] ev;
        logic [1:0] dc;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    disp_decimal_entry #(.MAX_DIGITS(3), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
        .neg_toggle(neg_toggle), .backspace(backspace), .enter(enter), .clear(clear),
        .non_signed(non_signed), .value_out(value_out), .value_valid(value_valid),
        .entry_active(entry_active), .entry_value(entry_value),
        .digit_count(digit_count), .entry_err(entry_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] s, input logic [3:0] d, input logic ns,
                                input logic [7:0] vo, input logic vv, input logic ea,
                                input logic [7:0] ev, input logic [1:0] dc, input logic er);
        vec_t v;
        v.strobes = s; v.dig = d; v.ns = ns; v.vo = vo; v.vv = vv;
        v.ea = ea; v.ev = ev; v.dc = dc; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] vo, input logic vv, input logic ea,
                           input logic [7:0] ev, input logic [1:0] dc, input logic er);
        chk({tag, ".value_out"},    int'(value_out),    int'(vo));
        chk({tag, ".value_valid"},  int'(value_valid),  int'(vv));
        chk({tag, ".entry_active"}, int'(entry_active), int'(ea));
        chk({tag, ".entry_value"},  int'(entry_value),  int'(ev));
        chk({tag, ".digit_count"},  int'(digit_count),  int'(dc));
        chk({tag, ".entry_err"},    int'(entry_err),    int'(er));
    endtask

    task automatic step(input logic [4:0] s, input logic [3:0] d, input logic ns);
        {clear, enter, backspace, neg_toggle, digit_valid} = s;
        digit      = d;
        non_signed = ns;
        @(posedge clk);
        #1;
        {clear, enter, backspace, neg_toggle, digit_valid} = 5'b0;
        n_vec++;
    endtask

    initial begin
        // Signed 127, then full-scale negative entry
        vecs.push_back(mk(5'b00001, 4'd1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 2'd1, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h0C, 2'd2, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd7, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7F, 2'd3, 1'b0));
        vecs.push_back(mk(5'b01000, 4'd0, 1'b0, 8'h7F, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0));
        vecs.push_back(mk(5'b00000, 4'd0, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0));
        vecs.push_back(mk(5'b00010, 4'd0, 1'b0, 8'h7F, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd1, 1'b0, 8'h7F, 1'b0, 1'b1, 8'hFF, 2'd1, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd2, 1'b0, 8'h7F, 1'b0, 1'b1, 8'hF4, 2'd2, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd8, 1'b0, 8'h7F, 1'b0, 1'b1, 8'h80, 2'd3, 1'b0));
        vecs.push_back(mk(5'b01000, 4'd0, 1'b0, 8'h80, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0));
        // +128 accepted as digits but rejected on enter
        vecs.push_back(mk(5'b00001, 4'd1, 1'b0, 8'h80, 1'b0, 1'b1, 8'h01, 2'd1, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd2, 1'b0, 8'h80, 1'b0, 1'b1, 8'h0C, 2'd2, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd8, 1'b0, 8'h80, 1'b0, 1'b1, 8'h80, 2'd3, 1'b0));
        vecs.push_back(mk(5'b01000, 4'd0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h80, 2'd3, 1'b1));
        vecs.push_back(mk(5'b10000, 4'd0, 1'b0, 8'h80, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0));
        // Unsigned 255 with an overflowing digit rejected
        vecs.push_back(mk(5'b00001, 4'd2, 1'b1, 8'h80, 1'b0, 1'b1, 8'h02, 2'd1, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd5, 1'b1, 8'h80, 1'b0, 1'b1, 8'h19, 2'd2, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd6, 1'b1, 8'h80, 1'b0, 1'b1, 8'h19, 2'd2, 1'b1));
        vecs.push_back(mk(5'b00001, 4'd5, 1'b1, 8'h80, 1'b0, 1'b1, 8'hFF, 2'd3, 1'b0));
        vecs.push_back(mk(5'b01000, 4'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0));
        // Backspace down to IDLE, then enter+clear together
        vecs.push_back(mk(5'b00001, 4'd4, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h04, 2'd1, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd5, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h2D, 2'd2, 1'b0));
        vecs.push_back(mk(5'b00100, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h04, 2'd1, 1'b0));
        vecs.push_back(mk(5'b00100, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0));
        vecs.push_back(mk(5'b00100, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd9, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h09, 2'd1, 1'b0));
        vecs.push_back(mk(5'b11000, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0));
        // Mode switched mid-entry
        vecs.push_back(mk(5'b00001, 4'd2, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h02, 2'd1, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h14, 2'd2, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hC8, 2'd3, 1'b0));
        vecs.push_back(mk(5'b01000, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hC8, 2'd3, 1'b1));
        vecs.push_back(mk(5'b01000, 4'd0, 1'b1, 8'hC8, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0));
        // Digit limit, non-BCD digit, priority among simultaneous strobes
        vecs.push_back(mk(5'b00001, 4'd1, 1'b0, 8'hC8, 1'b0, 1'b1, 8'h01, 2'd1, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd0, 1'b0, 8'hC8, 1'b0, 1'b1, 8'h0A, 2'd2, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd0, 1'b0, 8'hC8, 1'b0, 1'b1, 8'h64, 2'd3, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd0, 1'b0, 8'hC8, 1'b0, 1'b1, 8'h64, 2'd3, 1'b1));
        vecs.push_back(mk(5'b00001, 4'd12, 1'b0, 8'hC8, 1'b0, 1'b1, 8'h64, 2'd3, 1'b0));
        vecs.push_back(mk(5'b00110, 4'd0, 1'b0, 8'hC8, 1'b0, 1'b1, 8'h0A, 2'd2, 1'b0));
        vecs.push_back(mk(5'b00011, 4'd5, 1'b0, 8'hC8, 1'b0, 1'b1, 8'hF6, 2'd2, 1'b0));
        vecs.push_back(mk(5'b01000, 4'd0, 1'b0, 8'hF6, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0));
        vecs.push_back(mk(5'b00010, 4'd0, 1'b1, 8'hF6, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0));
        vecs.push_back(mk(5'b01000, 4'd0, 1'b1, 8'hF6, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd12, 1'b0, 8'hF6, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0));
        vecs.push_back(mk(5'b00001, 4'd7, 1'b0, 8'hF6, 1'b0, 1'b1, 8'h07, 2'd1, 1'b0));
        vecs.push_back(mk(5'b01100, 4'd0, 1'b0, 8'h07, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0));

        rst_n = 1'b0;
        {clear, enter, backspace, neg_toggle, digit_valid} = 5'b0;
        digit = 4'd0;
        non_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].strobes, vecs[i].dig, vecs[i].ns);
            chk_all($sformatf("v%0d", i + 1), vecs[i].vo, vecs[i].vv, vecs[i].ea,
                    vecs[i].ev, vecs[i].dc, vecs[i].er);
        end

        // Asynchronous reset in the middle of an entry
        step(5'b00001, 4'd1, 1'b0);
        step(5'b00001, 4'd2, 1'b0);
        chk_all("pre_rst", 8'h07, 1'b0, 1'b1, 8'h0C, 2'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        step(5'b01000, 4'd0, 1'b0);
        chk_all("rst_held", 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        rst_n = 1'b1;

`ifdef DEC_ENTRY_TIMEOUT_EN
        step(5'b00001, 4'd3, 1'b0);
        chk_all("to_start", 8'h00, 1'b0, 1'b1, 8'h03, 2'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(5'b00000, 4'd0, 1'b0);
            chk_all($sformatf("to_wait%0d", k), 8'h00, 1'b0, 1'b1, 8'h03, 2'd1, 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            step(5'b00000, 4'd0, 1'b0);
            chk($sformatf("to_vv%0d", k), int'(value_valid), 0);
            chk($sformatf("to_err%0d", k), int'(entry_err), 0);
        end
        chk_all("to_done", 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
